uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised, oversampled UART receiver; next generation of the team's fixed 8N1 receiver.
- Adds configurable data width, oversample ratio and stop-bit count.
- Adds runtime parity, false-start rejection, parity/framing error flags and a registered done pulse.
- Sits between the baud-tick generator (s_tick source) and the downstream byte consumer or anomaly-detector front end.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), received LSB first
OVERSAMPLE, 16, s_tick pulses per bit period (even, 8..32)
STOP_BITS, 1, stop bits checked per frame (1 or 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
s_tick  input  1  oversample enable, one-clk pulse, OVERSAMPLE per bit
parity_en  input  1  1 = parity bit follows data
parity_odd  input  1  1 = odd parity, 0 = even parity
data_out  output  DATA_BITS  last received word, held until next frame completes
rx_done_tick  output  1  one-clk pulse, frame complete
parity_err  output  1  parity mismatch on last frame, valid with rx_done_tick, held
frame_err  output  1  any stop bit sampled low on last frame, valid with rx_done_tick, held

Behaviour:
- Reset: asynchronous, active-low. All registers clear; state=IDLE; synchroniser flops set to 1; all outputs 0.
- rx passes through a 2-flop synchroniser (rx_s). All FSM decisions use rx_s only; this adds 2 clk of input latency.
- Counters: s_cnt is $clog2(OVERSAMPLE) bits; n_cnt is $clog2(DATA_BITS) bits. Counters advance only on cycles with s_tick=1.
- IDLE: rx_s==0 -> START, s_cnt=0.
- START: at s_cnt==OVERSAMPLE/2-1 (mid start bit):
  - rx_s==0 -> DATA; clear s_cnt and n_cnt; latch parity_en and parity_odd into internal config registers.
  - rx_s==1 -> IDLE (glitch rejected, no output activity).
- DATA: at s_cnt==OVERSAMPLE-1, shift rx_s into MSB of shift register (right-shift, LSB first).
  - After DATA_BITS samples: latched parity_en=1 -> PARITY, else -> STOP.
- PARITY: at s_cnt==OVERSAMPLE-1, compute perr = (XOR of data bits ^ rx_s) != latched parity_odd, then -> STOP.
- STOP: sample at s_cnt==OVERSAMPLE-1 of each stop bit; OR any low sample into ferr.
  - After STOP_BITS samples -> IDLE.
  - On the clk after the final stop sample: data_out <= shift register, parity_err <= perr (0 if parity disabled), frame_err <= ferr, rx_done_tick=1 for exactly one clk.
- rx_done_tick is registered, never combinational.
- Config inputs changing mid-frame have no effect until the next start-bit validation.
- A start bit arriving in the same clk as rx_done_tick is accepted; IDLE is re-entered that clk.
- s_tick absent: FSM holds in its current state indefinitely.
- Reset mid-frame: frame is discarded, no done pulse, flags cleared.

Optional Feature:
UART_RX_BREAK_DET_EN
- Defined:
  - Adds output break_tick (1 bit, reset 0).
  - A frame with all data bits, the parity bit (if enabled) and all stop bits sampled 0 pulses break_tick together with rx_done_tick (frame_err=1).
  - FSM then enters BRK_WAIT and stays there until rx_s==1; only then does it return to IDLE.
- Undefined: no break_tick port; no BRK_WAIT state; a line held low re-enters START immediately after IDLE.

Decomposition:
- uart_pkg holds:
  - state encoding constants: IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  - parity mode constants
  - function computing counter width from a parameter
- One sub-module: uart_sync2 (2-flop synchroniser, reset value parameterised, here 1), shared with future UART blocks.

Test Plan:
1. Defaults, parity_en=0; send 0xA5, 1 stop bit -> single rx_done_tick, data_out=0xA5, parity_err=0, frame_err=0.
2. parity_en=1, parity_odd=0; send 0x03 with parity bit 1 -> parity_err=1; resend with parity bit 0 -> parity_err=0, data_out=0x03.
3. rx low for 4 s_ticks then high -> no rx_done_tick; FSM back in IDLE; a following 0x5A frame is received correctly.
4. STOP_BITS=2; send 0x7E with second stop bit 0 -> frame_err=1, data_out=0x7E.
5. Assert rst_n=0 mid-way through data bit 4, release, send 0x81 -> only one done pulse, data_out=0x81, flags 0.
6. UART_RX_BREAK_DET_EN defined; hold rx low for 3 frame times -> one break_tick together with rx_done_tick; no further frames until rx returns high; a subsequent 0x55 frame is received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive blocks: FSM state encodings,
// parity mode encoding and a counter-width helper.
package uart_pkg;

  // FSM state encodings (kept as plain constants for legacy compatibility)
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] PARITY   = 3'd3;
  localparam logic [2:0] STOP     = 3'd4;
  localparam logic [2:0] BRK_WAIT = 3'd5;

  // Parity mode as carried on parity_odd
  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_t;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets the value both flops take during reset (idle level of the line).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; the first stage may go metastable, the second settles it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable data width, oversample ratio
// and stop-bit count, runtime parity selection, false-start rejection,
// parity/framing error flags and a registered done pulse.
// Optional: define UART_RX_BREAK_DET_EN to add break detection (break_tick
// output and a BRK_WAIT state that holds until the line returns high).
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 s_tick,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done_tick,
  output logic                 parity_err,
  output logic                 frame_err
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 break_tick
`endif
);

  localparam int unsigned SW = cnt_width(OVERSAMPLE);
  localparam int unsigned NW = cnt_width(DATA_BITS);

  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END     = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state;
  logic [SW-1:0]        s_cnt;
  logic [NW-1:0]        n_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pen_q;
  parity_mode_t         pmode_q;
  logic                 perr;
  logic                 ferr;
  logic                 par_calc;
`ifdef UART_RX_BREAK_DET_EN
  logic                 all_zero;
`endif

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Parity over the received data plus the parity bit currently on the line
  always_comb begin
    par_calc = (^shreg) ^ rx_s;
  end

  // Receive FSM, bit counters, shift register and registered frame outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shreg        <= '0;
      pen_q        <= 1'b0;
      pmode_q      <= PAR_EVEN;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      data_out     <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      all_zero     <= 1'b0;
      break_tick   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_tick   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end

        START: begin
          if (s_tick) begin
            if (s_cnt == S_MID) begin
              if (!rx_s) begin
                // Valid start bit: snapshot the frame configuration here so
                // later changes on the config pins cannot disturb this frame
                state   <= DATA;
                s_cnt   <= '0;
                n_cnt   <= '0;
                pen_q   <= parity_en;
                pmode_q <= parity_mode_t'(parity_odd);
                perr    <= 1'b0;
                ferr    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                all_zero <= 1'b1;
`endif
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s_cnt == S_END) begin
              s_cnt <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DET_EN
              all_zero <= all_zero & ~rx_s;
`endif
              if (n_cnt == N_LAST) begin
                n_cnt <= '0;
                state <= pen_q ? PARITY : STOP;
              end else begin
                n_cnt <= n_cnt + NW'(1);
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

        PARITY: begin
          if (s_tick) begin
            if (s_cnt == S_END) begin
              s_cnt <= '0;
              perr  <= (par_calc != (pmode_q == PAR_ODD));
`ifdef UART_RX_BREAK_DET_EN
              all_zero <= all_zero & ~rx_s;
`endif
              state <= STOP;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s_cnt == S_END) begin
              s_cnt <= '0;
              if (n_cnt == STOP_LAST) begin
                // Final stop sample is folded straight into the output
                // registers so the done pulse lands on the next clk
                n_cnt        <= '0;
                data_out     <= shreg;
                parity_err   <= perr;
                frame_err    <= ferr | ~rx_s;
                rx_done_tick <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                if (all_zero && !rx_s) begin
                  break_tick <= 1'b1;
                  state      <= BRK_WAIT;
                end else begin
                  state <= IDLE;
                end
`else
                state <= IDLE;
`endif
              end else begin
                ferr  <= ferr | ~rx_s;
                n_cnt <= n_cnt + NW'(1);
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

`ifdef UART_RX_BREAK_DET_EN
        BRK_WAIT: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: one instance with a single stop bit (line A)
// and one with two stop bits (line B), driven from a table of frames plus
// hand-written sequences for glitches, tick stalls, mid-frame reset and
// config changes, and a held-low line (break detection when
// UART_RX_BREAK_DET_EN is defined).
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       s_tick = 1'b0;
  logic       tick_en = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] data_a, data_b;
  logic       done_a, done_b, perr_a, perr_b, ferr_a, ferr_b;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk_a, brk_b;
  int         n_brk_a = 0;
  int         n_brk_lone = 0;
`endif

  int total = 0;
  int bad = 0;
  int n_done_a = 0;
  int n_done_b = 0;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx_a),
    .s_tick       (s_tick),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .data_out     (data_a),
    .rx_done_tick (done_a),
    .parity_err   (perr_a),
    .frame_err    (ferr_a)
`ifdef UART_RX_BREAK_DET_EN
    ,
    .break_tick   (brk_a)
`endif
  );

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx_b),
    .s_tick       (s_tick),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .data_out     (data_b),
    .rx_done_tick (done_b),
    .parity_err   (perr_b),
    .frame_err    (ferr_b)
`ifdef UART_RX_BREAK_DET_EN
    ,
    .break_tick   (brk_b)
`endif
  );

  always #5 clk = ~clk;

  // One s_tick every third clock, changed on the falling edge
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      s_tick = (tick_en && div == 2);
      div = (div == 2) ? 0 : div + 1;
    end
  end

  // Count done (and break) pulses, one count per clk they are high
  always @(negedge clk) begin
    if (done_a) n_done_a <= n_done_a + 1;
    if (done_b) n_done_b <= n_done_b + 1;
`ifdef UART_RX_BREAK_DET_EN
    if (brk_a) n_brk_a <= n_brk_a + 1;
    if ((brk_a && !done_a) || (brk_b && !done_b)) n_brk_lone <= n_brk_lone + 1;
`endif
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      @(posedge clk);
      while (s_tick !== 1'b1 && g < 10) begin
        @(posedge clk);
        g++;
      end
      if (g >= 10) begin
        total++;
        bad++;
        $display("FAIL tick_wait: got no s_tick expected one within 10 clk");
      end
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    if (sel) rx_b = b;
    else     rx_a = b;
    wait_ticks(n);
  endtask

  // A low final stop bit is held only 12 ticks so the receiver's re-entered
  // start check at mid-bit sees the line high again and rejects it
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic s1, input logic s2);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    if (pen) send_bit(pbit, 16);
    if (!sel) begin
      send_bit(s1, s1 ? 16 : 12);
    end else begin
      send_bit(s1, 16);
      send_bit(s2, s2 ? 16 : 12);
    end
    send_bit(1'b1, 40);
  endtask

  typedef struct {
    logic       line;
    logic [7:0] d;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int ba, bb;

    //           line d      pen podd pb s1 s2 exp_d  perr ferr
    vecs[0]  = '{1'b0, 8'hA5, 0, 0, 0, 1, 1, 8'hA5, 0, 0};
    vecs[1]  = '{1'b0, 8'h03, 1, 0, 1, 1, 1, 8'h03, 1, 0};
    vecs[2]  = '{1'b0, 8'h03, 1, 0, 0, 1, 1, 8'h03, 0, 0};
    vecs[3]  = '{1'b0, 8'h03, 1, 1, 1, 1, 1, 8'h03, 0, 0};
    vecs[4]  = '{1'b0, 8'hFF, 1, 1, 1, 1, 1, 8'hFF, 0, 0};
    vecs[5]  = '{1'b0, 8'h80, 1, 0, 0, 1, 1, 8'h80, 1, 0};
    vecs[6]  = '{1'b0, 8'h80, 1, 1, 0, 1, 1, 8'h80, 0, 0};
    vecs[7]  = '{1'b0, 8'h3C, 0, 0, 0, 0, 1, 8'h3C, 0, 1};
    vecs[8]  = '{1'b0, 8'h01, 1, 0, 1, 0, 1, 8'h01, 0, 1};
    vecs[9]  = '{1'b0, 8'h00, 0, 0, 0, 1, 1, 8'h00, 0, 0};
    vecs[10] = '{1'b1, 8'h3C, 0, 0, 0, 1, 1, 8'h3C, 0, 0};
    vecs[11] = '{1'b1, 8'h7E, 0, 0, 0, 1, 0, 8'h7E, 0, 1};
    vecs[12] = '{1'b1, 8'h96, 1, 1, 0, 0, 1, 8'h96, 1, 1};
    vecs[13] = '{1'b1, 8'hA5, 1, 0, 0, 1, 1, 8'hA5, 0, 0};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_data_a", data_a, 8'h00);
    check("rst_done_a", done_a, 1'b0);
    check("rst_perr_a", perr_a, 1'b0);
    check("rst_ferr_a", ferr_a, 1'b0);
    rst_n = 1'b1;
    send_bit(1'b1, 40);
    check("idle_no_done", n_done_a + n_done_b, 0);

    // Table of frames
    for (int i = 0; i < 14; i++) begin
      sel        = vecs[i].line;
      parity_en  = vecs[i].pen;
      parity_odd = vecs[i].podd;
      ba = n_done_a;
      bb = n_done_b;
      send_frame(vecs[i].d, vecs[i].pen, vecs[i].pbit, vecs[i].s1, vecs[i].s2);
      if (!vecs[i].line) begin
        check($sformatf("v%0d_done_a", i), n_done_a - ba, 1);
        check($sformatf("v%0d_quiet_b", i), n_done_b - bb, 0);
        check($sformatf("v%0d_data_a", i), data_a, vecs[i].exp_d);
        check($sformatf("v%0d_perr_a", i), perr_a, vecs[i].exp_perr);
        check($sformatf("v%0d_ferr_a", i), ferr_a, vecs[i].exp_ferr);
      end else begin
        check($sformatf("v%0d_done_b", i), n_done_b - bb, 1);
        check($sformatf("v%0d_quiet_a", i), n_done_a - ba, 0);
        check($sformatf("v%0d_data_b", i), data_b, vecs[i].exp_d);
        check($sformatf("v%0d_perr_b", i), perr_b, vecs[i].exp_perr);
        check($sformatf("v%0d_ferr_b", i), ferr_b, vecs[i].exp_ferr);
      end
    end

    // Short start glitch is rejected, next frame still received
    sel = 1'b0;
    parity_en = 1'b0;
    ba = n_done_a;
    send_bit(1'b0, 4);
    send_bit(1'b1, 40);
    check("glitch_no_done", n_done_a - ba, 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    check("glitch_next_done", n_done_a - ba, 1);
    check("glitch_next_data", data_a, 8'h5A);

    // Config pins changed mid-frame must not affect the frame in flight
    parity_en = 1'b1;
    parity_odd = 1'b0;
    ba = n_done_a;
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h3C >> i), 16);
    parity_en = 1'b0;
    parity_odd = 1'b1;
    for (int i = 4; i < 8; i++) send_bit(1'(8'h3C >> i), 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 40);
    check("cfg_latch_done", n_done_a - ba, 1);
    check("cfg_latch_data", data_a, 8'h3C);
    check("cfg_latch_perr", perr_a, 1'b1);
    parity_odd = 1'b0;

    // s_tick stalled mid-frame: receiver must wait, then finish normally
    ba = n_done_a;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(1'(8'hC3 >> i), 16);
    tick_en = 1'b0;
    repeat (300) @(negedge clk);
    check("stall_no_done", n_done_a - ba, 0);
    tick_en = 1'b1;
    for (int i = 3; i < 8; i++) send_bit(1'(8'hC3 >> i), 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 40);
    check("stall_done", n_done_a - ba, 1);
    check("stall_data", data_a, 8'hC3);
    check("stall_ferr", ferr_a, 1'b0);

    // Reset in the middle of data bit 4 discards the frame
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hE7 >> i), 16);
    send_bit(1'b0, 8);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_data", data_a, 8'h00);
    check("midrst_ferr", ferr_a, 1'b0);
    rst_n = 1'b1;
    send_bit(1'b1, 40);
    ba = n_done_a;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
    check("midrst_next_done", n_done_a - ba, 1);
    check("midrst_next_data", data_a, 8'h81);
    check("midrst_next_perr", perr_a, 1'b0);
    check("midrst_next_ferr", ferr_a, 1'b0);

    // Line held low for a long stretch
    ba = n_done_a;
`ifdef UART_RX_BREAK_DET_EN
    bb = n_brk_a;
    send_bit(1'b0, 480);
    send_bit(1'b1, 48);
    check("brk_done", n_done_a - ba, 1);
    check("brk_tick", n_brk_a - bb, 1);
    check("brk_with_done", n_brk_lone, 0);
    check("brk_data", data_a, 8'h00);
    check("brk_ferr", ferr_a, 1'b1);
    ba = n_done_a;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    check("brk_next_done", n_done_a - ba, 1);
    check("brk_next_data", data_a, 8'h55);
    check("brk_next_ferr", ferr_a, 1'b0);
`else
    // Restarts straight after each frame: two all-zero frames, then a third
    // whose last three data bits see the line back high (0xE0, good stop)
    send_bit(1'b0, 400);
    send_bit(1'b1, 200);
    check("low_done", n_done_a - ba, 3);
    check("low_data", data_a, 8'hE0);
    check("low_ferr", ferr_a, 1'b0);
    ba = n_done_a;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    check("low_next_done", n_done_a - ba, 1);
    check("low_next_data", data_a, 8'h55);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
